// File: rtl/if_id_buf.sv
// ----------------------------------------------------------------------------
// if_id_buf -- IF/ID pipeline skid buffer
//
// A 2-entry in-order FIFO of {pc, inst} beats between fetch and decode. All
// outputs come from registered state (and the reset input), so fetch-side
// inputs never reach the decode side combinationally. A pushed beat appears
// on the outputs one cycle after it is accepted.
//
// Parameters
//   NOP_INST     instruction shown on inst_o while the buffer is empty
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   rst_i        synchronous, active-low reset
//   pc_i/inst_i  beat offered by fetch
//   valid_i      fetch offers a beat this cycle
//   ready_o      buffer can accept a beat this cycle (count < 2, not in reset)
//   flush_i      drop every buffered and in-flight beat (redirect)
//   pc_o/inst_o  head entry, towards decode (0 / NOP_INST when empty)
//   valid_o      head entry is valid
//   ready_i      decode consumes the head entry this cycle
//   stall_cnt_o  (IF_ID_STALL_CNT_EN only) saturating count of cycles where
//                the head is valid but decode is not ready; cleared by reset
//
// Build options
//   IF_ID_STALL_CNT_EN  define to add the stall counter and stall_cnt_o.
// ----------------------------------------------------------------------------
module if_id_buf #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        flush_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
`ifdef IF_ID_STALL_CNT_EN
    output logic [31:0] stall_cnt_o,
`endif
    input  logic        ready_i
);

    localparam int unsigned Depth = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    entry_t      mem_q [Depth];
    entry_t      mem_d [Depth];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q,  count_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic   empty;
    logic   full;
    logic   push;
    logic   pop;
    entry_t head;

    // While reset is held the buffer looks empty and refuses beats, even on
    // the very first reset cycle before the flops have been cleared.
    assign empty = (count_q == 2'd0) || !rst_i;
    assign full  = (count_q == 2'd2);
    assign head  = mem_q[rd_ptr_q];

    assign ready_o = rst_i && !full;
    assign valid_o = !empty;
    assign pc_o    = empty ? 32'h0000_0000 : head.pc;
    assign inst_o  = empty ? NOP_INST      : head.inst;

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            // Flush wins over any same-cycle push or pop. Pointers are
            // realigned so the next beat lands in entry 0.
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: pc_i, inst: inst_i};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional stall counter
    // ------------------------------------------------------------------------
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Flush deliberately does not clear this; it counts over the whole run.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_o && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    // ------------------------------------------------------------------------
    // Sanity properties
    // ------------------------------------------------------------------------
    // Occupancy never exceeds the two entries.
    a_count_range : assert property (@(posedge clk_i) disable iff (!rst_i)
        count_q <= 2'd2);

    // Pointer distance always matches occupancy (mod 2).
    a_ptr_consistent : assert property (@(posedge clk_i) disable iff (!rst_i)
        (wr_ptr_q - rd_ptr_q) == count_q[0]);

    // A stalled head holds steady until consumed or flushed.
    a_hold_stable : assert property (@(posedge clk_i) disable iff (!rst_i)
        (valid_o && !ready_i && !flush_i) |=>
            (!rst_i || (valid_o && $stable(pc_o) && $stable(inst_o))));

endmodule

// File: tb/tb_if_id_buf.sv
module tb_if_id_buf;

    localparam logic [31:0] Nop = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        ready_i;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_id_buf #(.NOP_INST(Nop)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .pc_i       (pc_i),
        .inst_i     (inst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .flush_i    (flush_i),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .valid_o    (valid_o),
`ifdef IF_ID_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .ready_i    (ready_i)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a beat whose instruction word is derived from its pc.
    task automatic offer(input logic [31:0] pc);
        valid_i = 1'b1;
        pc_i    = pc;
        inst_i  = 32'hC0DE_0000 | pc;
        #1;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        pc_i    = 32'hDEAD_BEEF;
        inst_i  = 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic test_reset();
        rst_i   = 1'b0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        offer(32'h0000_0100);
        step();
        step();
        n_checks++;
        if (ready_o !== 1'b0) begin
            $display("FAIL reset_ready: got %0b want 0", ready_o); n_fail++;
        end
        n_checks++;
        if (valid_o !== 1'b0) begin
            $display("FAIL reset_valid: got %0b want 0", valid_o); n_fail++;
        end
        n_checks++;
        if (inst_o !== 32'h00000013) begin
            $display("FAIL reset_inst: got %h want 00000013", inst_o); n_fail++;
        end
        n_checks++;
        if (pc_o !== 32'h0) begin
            $display("FAIL reset_pc: got %h want 0", pc_o); n_fail++;
        end
        idle();
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1) begin
            $display("FAIL reset_release_ready: got %0b want 1", ready_o); n_fail++;
        end
        n_checks++;
        if (valid_o !== 1'b0) begin
            $display("FAIL reset_release_valid: got %0b want 0", valid_o); n_fail++;
        end
    endtask

    task automatic test_stream();
        ready_i = 1'b1;
        offer(32'h0);
        n_checks++;
        if (valid_o !== 1'b0) begin
            $display("FAIL stream_no_comb_path: got %0b want 0", valid_o); n_fail++;
        end
        step();
        offer(32'h4);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'hC0DE_0000) begin
            $display("FAIL stream_beat0: got v=%0b pc=%h inst=%h want v=1 pc=0 inst=c0de0000",
                     valid_o, pc_o, inst_o);
            n_fail++;
        end
        step();
        offer(32'h8);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h4) begin
            $display("FAIL stream_beat1: got v=%0b pc=%h want v=1 pc=4", valid_o, pc_o);
            n_fail++;
        end
        step();
        idle();
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h8 || inst_o !== 32'hC0DE_0008) begin
            $display("FAIL stream_beat2: got v=%0b pc=%h inst=%h want v=1 pc=8 inst=c0de0008",
                     valid_o, pc_o, inst_o);
            n_fail++;
        end
        step();
        n_checks++;
        if (valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== Nop) begin
            $display("FAIL stream_empty: got v=%0b pc=%h inst=%h want v=0 pc=0 inst=00000013",
                     valid_o, pc_o, inst_o);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        offer(32'h10);
        step();
        offer(32'h14);
        n_checks++;
        if (ready_o !== 1'b1 || pc_o !== 32'h10) begin
            $display("FAIL bp_first: got rdy=%0b pc=%h want rdy=1 pc=10", ready_o, pc_o);
            n_fail++;
        end
        step();
        offer(32'h18);  // must be ignored while full
        n_checks++;
        if (ready_o !== 1'b0 || pc_o !== 32'h10) begin
            $display("FAIL bp_full: got rdy=%0b pc=%h want rdy=0 pc=10", ready_o, pc_o);
            n_fail++;
        end
        step();
        n_checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h10
            || inst_o !== 32'hC0DE_0010) begin
            $display("FAIL bp_hold: got rdy=%0b v=%0b pc=%h inst=%h want rdy=0 v=1 pc=10",
                     ready_o, valid_o, pc_o, inst_o);
            n_fail++;
        end
        idle();
        ready_i = 1'b1;
        #1;
        step();
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b1 || pc_o !== 32'h14) begin
            $display("FAIL bp_drain1: got rdy=%0b v=%0b pc=%h want rdy=1 v=1 pc=14",
                     ready_o, valid_o, pc_o);
            n_fail++;
        end
        step();
        n_checks++;
        if (valid_o !== 1'b0 || pc_o !== 32'h0) begin
            $display("FAIL bp_drain2: got v=%0b pc=%h want v=0 pc=0", valid_o, pc_o);
            n_fail++;
        end
        ready_i = 1'b0;
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        offer(32'h40);
        step();
        offer(32'h44);
        step();
        offer(32'h20);
        flush_i = 1'b1;
        #1;
        step();
        flush_i = 1'b0;
        idle();
        n_checks++;
        if (valid_o !== 1'b0 || inst_o !== Nop || pc_o !== 32'h0) begin
            $display("FAIL flush_full: got v=%0b pc=%h inst=%h want v=0 pc=0 inst=00000013",
                     valid_o, pc_o, inst_o);
            n_fail++;
        end
        step();
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            $display("FAIL flush_no_ghost: got v=%0b rdy=%0b want v=0 rdy=1", valid_o, ready_o);
            n_fail++;
        end
        // Flush at count 1 with a same-cycle push and pop.
        offer(32'h50);
        step();
        offer(32'h54);
        ready_i = 1'b1;
        flush_i = 1'b1;
        #1;
        step();
        flush_i = 1'b0;
        ready_i = 1'b0;
        idle();
        step();
        n_checks++;
        if (valid_o !== 1'b0 || pc_o !== 32'h0) begin
            $display("FAIL flush_push_pop: got v=%0b pc=%h want v=0 pc=0", valid_o, pc_o);
            n_fail++;
        end
    endtask

    task automatic test_push_pop();
        ready_i = 1'b0;
        offer(32'h30);
        step();
        offer(32'h34);
        ready_i = 1'b1;
        #1;
        step();
        idle();
        ready_i = 1'b0;
        #1;
        n_checks++;
        if (pc_o !== 32'h34 || valid_o !== 1'b1 || ready_o !== 1'b1) begin
            $display("FAIL push_pop: got pc=%h v=%0b rdy=%0b want pc=34 v=1 rdy=1",
                     pc_o, valid_o, ready_o);
            n_fail++;
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0) begin
            $display("FAIL push_pop_drain: got v=%0b want 0", valid_o); n_fail++;
        end
    endtask

    task automatic test_mid_reset();
        ready_i = 1'b0;
        offer(32'h60);
        step();
        offer(32'h64);
        step();
        idle();
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
            $display("FAIL midrst_during: got rdy=%0b v=%0b want rdy=0 v=0", ready_o, valid_o);
            n_fail++;
        end
        step();
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || inst_o !== Nop) begin
            $display("FAIL midrst_after: got rdy=%0b v=%0b inst=%h want rdy=1 v=0 inst=00000013",
                     ready_o, valid_o, inst_o);
            n_fail++;
        end
        // Entries are gone: a fresh beat is the first thing seen.
        ready_i = 1'b1;
        offer(32'h68);
        step();
        idle();
        n_checks++;
        if (pc_o !== 32'h68 || valid_o !== 1'b1) begin
            $display("FAIL midrst_fresh: got pc=%h v=%0b want pc=68 v=1", pc_o, valid_o);
            n_fail++;
        end
        step();
        ready_i = 1'b0;
    endtask

`ifdef IF_ID_STALL_CNT_EN
    task automatic test_stall_cnt();
        idle();
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (stall_cnt_o !== 32'd0) begin
            $display("FAIL stall_reset: got %0d want 0", stall_cnt_o); n_fail++;
        end
        ready_i = 1'b0;
        offer(32'h70);
        step();
        idle();
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (stall_cnt_o !== 32'd5) begin
            $display("FAIL stall_count: got %0d want 5", stall_cnt_o); n_fail++;
        end
        ready_i = 1'b1;
        flush_i = 1'b1;
        #1;
        step();
        flush_i = 1'b0;
        ready_i = 1'b0;
        step();
        n_checks++;
        if (stall_cnt_o !== 32'd5) begin
            $display("FAIL stall_flush: got %0d want 5", stall_cnt_o); n_fail++;
        end
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        n_checks++;
        if (stall_cnt_o !== 32'd0) begin
            $display("FAIL stall_clear: got %0d want 0", stall_cnt_o); n_fail++;
        end
    endtask
`endif

    initial begin
        rst_i   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        pc_i    = '0;
        inst_i  = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_push_pop();
        test_mid_reset();
`ifdef IF_ID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
